bram_port_arbiter: RTL

//  Shares one single-port block RAM between two requesters: port 0 is the AXI4-Lite slave register/BRAM front-end,

---
 rtl/bram_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin front end for one single-port block RAM.
// Port 0 is the AXI4-Lite side and port 1 is the user datapath. The arbiter
// accepts one command per cycle, registers it toward the BRAM, and returns
// read data on the port that issued the read.
//
// state   | meaning
// PRI_M0  | port 0 wins when both ports request (reset value)
// PRI_M1  | port 1 wins when both ports request
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1   // BRAM read latency from bram_en; 1 or 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  m0_req,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  bram_en,
  output logic [DATA_W/8-1:0]   bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  input  logic [DATA_W-1:0]     bram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } rr_t;

  rr_t rr_q, rr_nxt;

  logic              hs_any;
  logic              hs_port;
  logic [STRB_W-1:0] sel_wstrb;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              issue_port;
  logic              issue_rd;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_p;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Round-robin pointer register; it only moves on an accepted command.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rr_q <= PRI_M0;
    end else begin
      rr_q <= rr_nxt;
    end
  end

  // Grant decode and next pointer. Grants are masked while reset is asserted
  // so a requester holding req through reset is not told it was accepted.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    rr_nxt = rr_q;
    if (ARESETN) begin
      if (m0_req && (!m1_req || rr_q == PRI_M0)) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
    if (m0_gnt) begin
      rr_nxt = PRI_M1;
    end else if (m1_gnt) begin
      rr_nxt = PRI_M0;
    end
  end

  // Command mux: pick the fields of whichever port was granted.
  always_comb begin
    hs_any    = (m0_req & m0_gnt) | (m1_req & m1_gnt);
    hs_port   = m1_req & m1_gnt;
    sel_wstrb = hs_port ? m1_wstrb : m0_wstrb;
    sel_addr  = hs_port ? m1_addr  : m0_addr;
    sel_wdata = hs_port ? m1_wdata : m0_wdata;
  end

  // Issue register toward the BRAM; address and data hold when idle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      issue_port <= 1'b0;
    end else begin
      bram_en    <= hs_any;
      bram_we    <= hs_any ? sel_wstrb : '0;
      issue_port <= hs_port;
      if (hs_any) begin
        bram_addr  <= sel_addr;
        bram_wdata <= sel_wdata;
      end
    end
  end

  assign issue_rd = bram_en & ~(|bram_we);

  // Read tag pipe: the tag enters when the read is on the BRAM pins and
  // reaches the last stage in the cycle the BRAM presents the data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pipe_v <= '0;
      pipe_p <= '0;
    end else begin
      pipe_v[0] <= issue_rd;
      pipe_p[0] <= issue_port;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  assign m0_rvalid = pipe_v[RD_LAT-1] & ~pipe_p[RD_LAT-1];
  assign m1_rvalid = pipe_v[RD_LAT-1] &  pipe_p[RD_LAT-1];

  // Per-port read data holding registers, loaded only on that port's return.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= bram_rdata;
      if (m1_rvalid) rdata1_q <= bram_rdata;
    end
  end

  // The return cycle passes BRAM data straight through; afterwards the
  // holding register keeps the last value for that port.
  assign m0_rdata = m0_rvalid ? bram_rdata : rdata0_q;
  assign m1_rdata = m1_rvalid ? bram_rdata : rdata1_q;

endmodule
